blink_multi: RTL and testbench

//   N-channel LED blinker; successor to the single-channel fixed-rate blinker.
//   One shared prescaler produces a tick; each channel has its own mode and period, set at runtime.

---
 rtl/blink_pkg.sv | 13 +
 rtl/blink_multi_if.sv | 30 +++
 rtl/blink_chan.sv | 110 +++++++++++
 rtl/blink_multi.sv | 72 +++++++
 tb/tb_blink_multi.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared types for the multi-channel LED blinker.
package blink_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      OFF   = 2'b00,
      ON    = 2'b01,
      BLINK = 2'b10,
      BURST = 2'b11
   } mode_e;

endpackage

// File: rtl/blink_multi_if.sv
// Config/status bundle between the board-control register block and the blinker.
// master drives the config write; slave is the blinker itself.
interface blink_multi_if
   import blink_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int PER_BITS = 8
) ();

   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic                cfg_we;
   logic [CH_W-1:0]     cfg_ch;
   mode_e               cfg_mode;
   logic [PER_BITS-1:0] cfg_per;
   logic [NCH-1:0]      led;
   logic [NCH-1:0]      flg;
   logic [NCH-1:0]      busy;

   modport master (
      output cfg_we, cfg_ch, cfg_mode, cfg_per,
      input  led, flg, busy
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_mode, cfg_per,
      output led, flg, busy
   );

endinterface

// File: rtl/blink_chan.sv
// One blinker channel: mode/period registers, tick counter, burst counter,
// registered led/flg/busy. Priority: reset, config write, sync, tick.
// Optional BLINK_MULTI_SYNC_EN adds i_sync (phase realignment).
module blink_chan
   import blink_pkg::*;
#(
   parameter int PER_BITS = 8,
   parameter int DEF_PER  = 8,
   parameter int BURST_N  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_tick,
   input  logic                i_wr,
   input  mode_e               i_mode,
   input  logic [PER_BITS-1:0] i_per,
`ifdef BLINK_MULTI_SYNC_EN
   input  logic                i_sync,
`endif
   output logic                o_led,
   output logic                o_flg,
   output logic                o_busy
);

   localparam int BC_W = (BURST_N > 1) ? $clog2(BURST_N) : 1;

   mode_e               r_mode, w_mode_n;
   logic [PER_BITS-1:0] r_per, w_per_n;
   logic [PER_BITS-1:0] r_cnt, w_cnt_n;
   logic [BC_W-1:0]     r_bcnt, w_bcnt_n;
   logic                r_led, w_led_n;
   logic                r_flg, w_flg_n;
   logic                r_busy, w_busy_n;
   logic [PER_BITS-1:0] w_term;
   logic                w_run;

   // period 0 behaves like 1, so its terminal count is also 0
   assign w_term = (r_per == '0) ? '0 : r_per - 1'b1;
   assign w_run  = (r_mode == BLINK) || (r_mode == BURST);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= OFF;
         r_per  <= PER_BITS'(DEF_PER);
         r_cnt  <= '0;
         r_bcnt <= '0;
         r_led  <= 1'b0;
         r_flg  <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_mode <= w_mode_n;
         r_per  <= w_per_n;
         r_cnt  <= w_cnt_n;
         r_bcnt <= w_bcnt_n;
         r_led  <= w_led_n;
         r_flg  <= w_flg_n;
         r_busy <= w_busy_n;
      end
   end

   // next state: a write drops any coincident tick; flg only on a tick-driven toggle
   always_comb begin
      w_mode_n = r_mode;
      w_per_n  = r_per;
      w_cnt_n  = r_cnt;
      w_bcnt_n = r_bcnt;
      w_led_n  = r_led;
      w_flg_n  = 1'b0;
      w_busy_n = r_busy;
      if (i_wr) begin
         w_mode_n = i_mode;
         w_per_n  = i_per;
         w_cnt_n  = '0;
         w_bcnt_n = '0;
         w_led_n  = (i_mode == ON);
         w_busy_n = (i_mode == BURST);
      end
`ifdef BLINK_MULTI_SYNC_EN
      else if (i_sync) begin
         w_cnt_n = '0;
         if (w_run) w_led_n = 1'b0;
      end
`endif
      else if (i_tick && w_run) begin
         if (r_cnt == w_term) begin
            w_cnt_n = '0;
            w_led_n = ~r_led;
            w_flg_n = 1'b1;
            // a falling edge in BURST advances the pulse count
            if (r_mode == BURST && r_led) begin
               if (r_bcnt == BC_W'(BURST_N - 1)) begin
                  w_mode_n = OFF;
                  w_busy_n = 1'b0;
                  w_bcnt_n = '0;
               end else begin
                  w_bcnt_n = r_bcnt + 1'b1;
               end
            end
         end else begin
            w_cnt_n = r_cnt + 1'b1;
         end
      end
   end

   assign o_led  = r_led;
   assign o_flg  = r_flg;
   assign o_busy = r_busy;

endmodule

// File: rtl/blink_multi.sv
// N-channel LED blinker: shared prescaler tick, per-channel mode/period.
// Optional BLINK_MULTI_SYNC_EN adds sync_i to realign all channel phases.
module blink_multi
   import blink_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int PRE_BITS = 20,
   parameter int PER_BITS = 8,
   parameter int DEF_PER  = 8,
   parameter int BURST_N  = 3
) (
   input  logic clk,
   input  logic rst,
`ifdef BLINK_MULTI_SYNC_EN
   input  logic sync_i,
`endif
   blink_multi_if.slave bus
);

   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [PRE_BITS-1:0] r_pre_cnt;
   logic                w_tick;
   logic [NCH-1:0]      w_wr;
   logic [NCH-1:0]      w_led, w_flg, w_busy;

   // free-running prescaler
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre_cnt <= '0;
      end
`ifdef BLINK_MULTI_SYNC_EN
      else if (sync_i) begin
         r_pre_cnt <= '0;
      end
`endif
      else begin
         r_pre_cnt <= r_pre_cnt + 1'b1;
      end
   end

   assign w_tick = &r_pre_cnt;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      // channel select; indices past NCH never match
      assign w_wr[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

      blink_chan #(
         .PER_BITS (PER_BITS),
         .DEF_PER  (DEF_PER),
         .BURST_N  (BURST_N)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .i_tick (w_tick),
         .i_wr   (w_wr[i]),
         .i_mode (bus.cfg_mode),
         .i_per  (bus.cfg_per),
`ifdef BLINK_MULTI_SYNC_EN
         .i_sync (sync_i),
`endif
         .o_led  (w_led[i]),
         .o_flg  (w_flg[i]),
         .o_busy (w_busy[i])
      );
   end

   assign bus.led  = w_led;
   assign bus.flg  = w_flg;
   assign bus.busy = w_busy;

endmodule

// File: tb/tb_blink_multi.sv
// Directed bench for blink_multi with PRE_BITS=2 (tick every 4 cycles), PER_BITS=4, NCH=4, BURST_N=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_blink_multi;
   import blink_pkg::*;

   logic clk;
   logic rst;
`ifdef BLINK_MULTI_SYNC_EN
   logic sync_i;
`endif
   logic [1:0] pre_m;
   int n_chk, n_fail;

   blink_multi_if #(.NCH(4), .PER_BITS(4)) bus ();

   blink_multi #(
      .NCH(4), .PRE_BITS(2), .PER_BITS(4), .DEF_PER(8), .BURST_N(3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
`ifdef BLINK_MULTI_SYNC_EN
      .sync_i (sync_i),
`endif
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // prescaler phase reference, used only to time writes
   always @(posedge clk) begin
`ifdef BLINK_MULTI_SYNC_EN
      if (rst || sync_i) pre_m <= 2'd0;
`else
      if (rst) pre_m <= 2'd0;
`endif
      else pre_m <= pre_m + 2'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic align(input int ph);
      for (int n = 0; n < 8 && pre_m != 2'(ph); n++) step();
   endtask

   // write is captured on the next rising edge; returns at the falling edge after it
   task automatic wr(input int ch, input mode_e m, input int per);
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = 2'(ch);
      bus.cfg_mode = m;
      bus.cfg_per  = 4'(per);
      step();
      bus.cfg_we   = 1'b0;
   endtask

   initial begin
      logic e_led, e_flg, e_busy;
      n_chk = 0; n_fail = 0;
      rst = 1'b1;
      bus.cfg_we = 1'b0; bus.cfg_ch = 2'd0; bus.cfg_mode = OFF; bus.cfg_per = 4'd0;
`ifdef BLINK_MULTI_SYNC_EN
      sync_i = 1'b0;
`endif
      repeat (3) step();
      chk("rst_led", bus.led, 0);
      chk("rst_flg", bus.flg, 0);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b0;

      // 1: idle after reset
      for (int k = 0; k < 100; k++) begin
         step();
         chk("t1_idle", {bus.led, bus.flg, bus.busy}, 0);
      end

      // 2: ch0 BLINK per=2; first tick edge is k=3, toggles at k=7,15,23,...
      align(0);
      wr(0, BLINK, 2);
      for (int k = 1; k <= 40; k++) begin
         step();
         e_led = (k >= 7) && (((k - 7) / 8) % 2 == 0);
         e_flg = (k >= 7) && ((k - 7) % 8 == 0);
         chk("t2_led0", bus.led[0], e_led);
         chk("t2_flg0", bus.flg[0], e_flg);
         chk("t2_other", {bus.led[3:1], bus.flg[3:1], bus.busy}, 0);
      end
      wr(0, OFF, 0);
      chk("t2_off", bus.led[0], 0);

      // ON mode: steady high, never a strobe
      wr(3, ON, 5);
      for (int k = 0; k < 8; k++) begin
         chk("on_led3", bus.led[3], 1);
         chk("on_flg3", bus.flg[3], 0);
         step();
      end
      wr(3, OFF, 0);
      chk("on_off", bus.led[3], 0);

      // 3: ch1 BURST per=1; toggles at k=3,7,...,23, ends OFF on third fall at k=23
      align(0);
      wr(1, BURST, 1);
      chk("t3_busy0", bus.busy[1], 1);
      for (int k = 1; k <= 40; k++) begin
         step();
         e_led  = (k >= 3) && (k < 23) && (((k - 3) / 4) % 2 == 0);
         e_flg  = (k >= 3) && (k <= 23) && ((k - 3) % 4 == 0);
         e_busy = (k < 23);
         chk("t3_led1", bus.led[1], e_led);
         chk("t3_flg1", bus.flg[1], e_flg);
         chk("t3_busy1", bus.busy[1], e_busy);
      end

      // 4: ch2 BLINK per=0 acts as per=1
      align(0);
      wr(2, BLINK, 0);
      for (int k = 1; k <= 20; k++) begin
         step();
         e_led = (k >= 3) && (((k - 3) / 4) % 2 == 0);
         e_flg = (k >= 3) && ((k - 3) % 4 == 0);
         chk("t4_led2", bus.led[2], e_led);
         chk("t4_flg2", bus.flg[2], e_flg);
      end
      wr(2, OFF, 0);

      // 5: ch0 rewrite on a tick edge (k=7) drops that tick; ch3 still toggles
      align(0);
      wr(0, BLINK, 1);            // k=0
      wr(3, BLINK, 1);            // k=1
      for (int k = 2; k <= 6; k++) begin
         step();
         if (k == 3) begin
            chk("t5_pre_led", {bus.led[3], bus.led[0]}, 2'b11);
            chk("t5_pre_flg", {bus.flg[3], bus.flg[0]}, 2'b11);
         end
      end
      wr(0, BLINK, 2);            // captured on tick edge k=7
      chk("t5_led0", bus.led[0], 0);
      chk("t5_flg0", bus.flg[0], 0);
      chk("t5_led3", bus.led[3], 0);
      chk("t5_flg3", bus.flg[3], 1);
      for (int k = 8; k <= 15; k++) begin
         step();
         if (k == 11) begin
            chk("t5_k11", {bus.led[0], bus.flg[0], bus.led[3], bus.flg[3]}, 4'b0011);
         end
         if (k == 15) begin
            chk("t5_k15", {bus.led[0], bus.flg[0], bus.led[3], bus.flg[3]}, 4'b1101);
         end
      end

      // 6: reset mid-burst
      align(0);
      wr(1, BURST, 1);
      repeat (5) step();          // k=5, first pulse high
      chk("t6_mid", {bus.led[1], bus.busy[1]}, 2'b11);
      rst = 1'b1;
      step();
      chk("t6_rst", {bus.led, bus.flg, bus.busy}, 0);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("t6_idle", {bus.led, bus.flg, bus.busy}, 0);
      end

`ifdef BLINK_MULTI_SYNC_EN
      // sync: ch0/ch2 one tick out of phase, realigned to rise together
      align(0);
      wr(0, BLINK, 2);            // k=0
      repeat (4) step();
      wr(2, BLINK, 2);            // k=5
      repeat (4) step();          // k=9
      chk("sy_pre", bus.led[0], 1);
      sync_i = 1'b1;
      step();
      sync_i = 1'b0;
      chk("sy_clr", {bus.led[2], bus.led[0]}, 0);
      for (int j = 1; j <= 8; j++) begin
         step();
         chk("sy_led", {bus.led[2], bus.led[0]}, (j == 8) ? 2'b11 : 2'b00);
         chk("sy_flg", {bus.flg[2], bus.flg[0]}, (j == 8) ? 2'b11 : 2'b00);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
